// File: rtl/mem_block_responder.sv
// Fixed-latency 128-bit block store answering cache ALLOCATE reads and WRITE_BACK writes.
// Handshake: a request (exactly one of mem_read/mem_write) is taken in IDLE; mem_ready pulses once, LATENCY cycles later.
module mem_block_responder #(
    parameter int LATENCY   = 8,
    parameter int ADDR_BITS = 6
) (
    input  logic         clk,
    input  logic         mem_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic [1:0]   dbg_state
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] CNT_INIT = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [127:0]           wdata_q, wdata_d;
    logic [127:0]           rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic [127:0]           store_q [DEPTH];
    logic [127:0]           store_d [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[27:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        store_d = store_q;
        case (state_q)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    op_wr_d = mem_write;
                    addr_d  = mem_addr[ADDR_BITS-1:0];
                    wdata_d = mem_wdata;
                    if (LATENCY == 1) begin
                        // No BUSY phase: read data is fetched straight from the incoming address.
                        state_d = RESP;
                        ready_d = 1'b1;
                        if (!mem_write) begin
                            rdata_d = store_q[mem_addr[ADDR_BITS-1:0]];
                        end
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = store_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                // Write commits here so a read accepted next cycle already sees it.
                state_d = IDLE;
                if (op_wr_q) begin
                    store_d[addr_q] = wdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            store_q <= store_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: table of block transactions, scoreboard on mem_ready, reset/abandon/LATENCY=1 sequences.
module tb_mem_block_responder;

    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         mem_reset_n;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic [1:0]   dbg_state;

    logic         l1_read, l1_write;
    logic [27:0]  l1_addr;
    logic [127:0] l1_wdata, l1_rdata;
    logic         l1_ready;
    logic [1:0]   l1_dbg;

    mem_block_responder #(.LATENCY(LAT), .ADDR_BITS(6)) u_dut (
        .clk(clk), .mem_reset_n(mem_reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    mem_block_responder #(.LATENCY(1), .ADDR_BITS(6)) u_dut_l1 (
        .clk(clk), .mem_reset_n(mem_reset_n), .mem_read(l1_read), .mem_write(l1_write),
        .mem_addr(l1_addr), .mem_wdata(l1_wdata), .mem_rdata(l1_rdata),
        .mem_ready(l1_ready), .dbg_state(l1_dbg)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every mem_ready pops one expected mem_rdata value.
    logic         ready_prev = 1'b0;
    logic [127:0] mon_exp;
    always @(negedge clk) begin
        if (mem_ready && ready_prev) check("ready_width", 128'(mem_ready & ready_prev), 128'd0);
        if (mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 128'(mem_ready), 128'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rdata", mem_rdata, mon_exp);
            end
        end
        ready_prev = mem_ready;
    end

    task automatic req(input logic wr, input logic [27:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp_rd, input int drop_after, output int ready_cyc);
        int   n;
        logic got;
        @(posedge clk); #1;
        mem_read  = !wr;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        exp_q.push_back(exp_rd);
        n   = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == drop_after) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            if (mem_ready) got = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 28'($urandom);
        mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        check("latency", 128'(n), 128'(LAT));
        if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
        ready_cyc = cycle;
    endtask

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DA = 128'hAAAA_5555_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] DB = 128'hBBBB_0001_0203_0405_0607_0809_0A0B_0C0D;
    localparam logic [127:0] DC = 128'hC0DE_CAFE_F00D_BEEF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DE = 128'hEEEE_EEEE_1111_1111_2222_2222_3333_3333;
    localparam logic [127:0] DF = 128'hF1F2_F3F4_F5F6_F7F8_F9FA_FBFC_FDFE_FF00;
    localparam logic [127:0] DG = 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

    vec_t vt [10];
    int   rc, prev_rc, cnt;

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Writes expect mem_rdata to still hold the last read's data.
        vt[0] = '{1'b0, 28'h0000005, 128'd0, 128'd0};
        vt[1] = '{1'b1, 28'h0000003, D1,     128'd0};
        vt[2] = '{1'b0, 28'h0000003, 128'd0, D1};
        vt[3] = '{1'b1, 28'h0000023, DA,     D1};
        vt[4] = '{1'b0, 28'h0000003, 128'd0, D1};
        vt[5] = '{1'b1, 28'h0000041, DB,     D1};
        vt[6] = '{1'b0, 28'h0000001, 128'd0, DB};
        vt[7] = '{1'b0, 28'h0000023, 128'd0, DA};
        vt[8] = '{1'b1, 28'h100003F, DC,     DA};
        vt[9] = '{1'b0, 28'h000003F, 128'd0, DC};

        mem_reset_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        l1_read = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);
        check("reset_state", 128'(dbg_state), 128'd0);
        mem_reset_n = 1'b1;

        prev_rc = 0;
        for (int i = 0; i < 10; i++) begin
            req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, 0, rc);
            if (i > 0) check("b2b_gap", 128'(rc - prev_rc), 128'(LAT + 1));
            prev_rc = rc;
        end

        // Both requests high is not a legal request and must be ignored.
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'h3; mem_wdata = DE;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (mem_ready) cnt++;
        end
        check("illegal_ready_count", 128'(cnt), 128'd0);
        check("illegal_state", 128'(dbg_state), 128'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        req(1'b0, 28'h3, 128'd0, D1, 0, rc);

        // Reset while a write is in BUSY.
        @(posedge clk); #1;
        mem_write = 1'b1; mem_addr = 28'h7; mem_wdata = DE;
        @(posedge clk); #1;
        mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #3 mem_reset_n = 1'b0;
        #1;
        check("midbusy_reset_ready", 128'(mem_ready), 128'd0);
        check("midbusy_reset_rdata", mem_rdata, 128'd0);
        check("midbusy_reset_state", 128'(dbg_state), 128'd0);
        repeat (2) @(posedge clk);
        #3 mem_reset_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (mem_ready) cnt++;
        end
        check("midbusy_ready_count", 128'(cnt), 128'd0);
        req(1'b0, 28'h7, 128'd0, 128'd0, 0, rc);
        req(1'b0, 28'h3, 128'd0, 128'd0, 0, rc);

        // Requester abandons the write after two cycles; it still completes.
        req(1'b1, 28'h9, DF, 128'd0, 2, rc);
        req(1'b0, 28'h9, 128'd0, DF, 0, rc);

        // LATENCY=1 instance.
        @(posedge clk); #1;
        l1_write = 1'b1; l1_addr = 28'h2; l1_wdata = DG;
        @(posedge clk); #1;
        check("l1_write_ready", 128'(l1_ready), 128'd1);
        l1_write = 1'b0;
        @(posedge clk); #1;
        check("l1_idle_ready", 128'(l1_ready), 128'd0);
        l1_read = 1'b1; l1_addr = 28'h2;
        @(posedge clk); #1;
        check("l1_read_ready", 128'(l1_ready), 128'd1);
        check("l1_read_rdata", l1_rdata, DG);
        l1_addr = 28'h5;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("l1_ready_pattern", 128'(l1_ready), 128'(i % 2));
        end
        check("l1_stream_rdata", l1_rdata, 128'd0);
        l1_read = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
